// File: rtl/ppu_scanout_ctrl.sv
// Framebuffer scanout sequencer. It walks the screen in raster order over the banked read port
// and forwards the returned pixels through a small FIFO as a flagged valid/ready stream.
module ppu_scanout_ctrl #(
    parameter int COLOR_WIDTH   = 16,
    parameter int SCREEN_X_SIZE = 800,
    parameter int SCREEN_Y_SIZE = 600,
    parameter int CORES_COUNT   = 10,
    parameter int BUFFER_ADDR_W = 32,
    parameter int FIFO_DEPTH    = 4,
    localparam int SEL_W        = $clog2(CORES_COUNT)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     frame_start,
    input  logic                     abort,
    output logic [BUFFER_ADDR_W-1:0] raddress,
    output logic [SEL_W-1:0]         rselect,
    output logic                     rd_issue,
    input  logic [COLOR_WIDTH-1:0]   rdata,
    output logic [COLOR_WIDTH-1:0]   pix_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     pix_sof,
    output logic                     pix_eol,
    output logic                     pix_eof,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int X_W     = $clog2(SCREEN_X_SIZE);
    localparam int Y_W     = $clog2(SCREEN_Y_SIZE);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = COLOR_WIDTH + 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [X_W-1:0]           x_q, x_d;
    logic [Y_W-1:0]           y_q, y_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [BUFFER_ADDR_W-1:0] addr_q, addr_d;
    logic                     inflight_q;
    logic                     sof_q, eol_q, eof_q;
    logic [ENTRY_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;

    logic             cur_sof, cur_eol, cur_eof, issue, push, pop;
    logic [CNT_W:0]   occupancy;
    logic [ENTRY_W-1:0] head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign cur_sof   = (x_q == '0) && (y_q == '0);
    assign cur_eol   = (x_q == X_W'(SCREEN_X_SIZE - 1));
    assign cur_eof   = cur_eol && (y_q == Y_W'(SCREEN_Y_SIZE - 1));
    // The pop in the current cycle is deliberately not credited, keeping the issue path short.
    assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    assign issue     = (state_q == RUN) && !abort && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign push      = inflight_q && !abort;
    assign pop       = pix_valid && pix_ready && !abort;

    assign rd_issue  = issue;
    assign raddress  = addr_q;
    assign rselect   = sel_q;
    assign busy      = (state_q != IDLE);
    assign head      = mem_q[rd_ptr_q];
    assign pix_valid = (count_q != '0);
    assign pix_data  = head[ENTRY_W-1:3];
    assign pix_sof   = head[2];
    assign pix_eol   = head[1];
    assign pix_eof   = head[0];

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        frame_done = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_d = RUN;
                        x_d     = '0;
                        y_d     = '0;
                        sel_d   = '0;
                        addr_d  = '0;
                    end
                end
                RUN: begin
                    // Counters stop on the last pixel so the read port keeps showing it afterwards.
                    if (issue) begin
                        if (cur_eof) begin
                            state_d = DRAIN;
                        end else begin
                            if (sel_q == SEL_W'(CORES_COUNT - 1)) begin
                                sel_d  = '0;
                                addr_d = addr_q + BUFFER_ADDR_W'(1);
                            end else begin
                                sel_d = sel_q + SEL_W'(1);
                            end
                            if (cur_eol) begin
                                x_d = '0;
                                y_d = y_q + Y_W'(1);
                            end else begin
                                x_d = x_q + X_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if ((count_q == '0) && !inflight_q) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            sel_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            inflight_q <= issue;
            if (issue) begin
                sof_q <= cur_sof;
                eol_q <= cur_eol;
                eof_q <= cur_eof;
            end
        end
    end

    // Flags travel one cycle behind the read so they meet rdata at the FIFO write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {rdata, sof_q, eol_q, eof_q};
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: doc/ppu_scanout_ctrl.md
# ppu_scanout_ctrl

Scanout read sequencer for the PPU framebuffer. On each `frame_start` it walks every pixel of the screen in raster order and drives the framebuffer's single read port (`raddress`, `rselect`; data returns one cycle later on `rdata`). Returned pixels pass through an internal FIFO to a valid/ready pixel stream carrying start-of-frame, end-of-line and end-of-frame flags. It sits between the banked framebuffer and the display/video-out logic.

## Interface
- `COLOR_WIDTH`, 16, pixel width.
- `SCREEN_X_SIZE`, 800, pixels per line.
- `SCREEN_Y_SIZE`, 600, lines per frame.
- `CORES_COUNT`, 10, framebuffer banks. `SCREEN_X_SIZE*SCREEN_Y_SIZE` must be divisible by `CORES_COUNT`.
- `BUFFER_ADDR_W`, 32, bank word address width.
- `FIFO_DEPTH`, 4, output FIFO entries. Minimum 3.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse that starts a frame. Honoured only in IDLE.
- `abort` in 1: flushes the block and returns it to IDLE.
- `raddress` out BUFFER_ADDR_W: bank word address, registered.
- `rselect` out $clog2(CORES_COUNT): bank select, registered.
- `rd_issue` out 1: high in the cycle a read is presented on `raddress`/`rselect`.
- `rdata` in COLOR_WIDTH: framebuffer read data, valid one cycle after `rd_issue`.
- `pix_data` out COLOR_WIDTH: stream pixel.
- `pix_valid` out 1: stream valid.
- `pix_ready` in 1: stream ready.
- `pix_sof` out 1: marks pixel 0.
- `pix_eol` out 1: marks the last pixel of a line.
- `pix_eof` out 1: marks the last pixel of the frame.
- `busy` out 1: high when the state is not IDLE.
- `frame_done` out 1: one-cycle pulse when a frame completes.

## Operation
- **Pixel mapping.** Pixel index p = y*SCREEN_X_SIZE + x.
  - Bank = p mod CORES_COUNT. Address = p div CORES_COUNT.
  - This is implemented with counters, not dividers. `rselect` counts 0..CORES_COUNT-1 and wraps to 0. `raddress` increments when `rselect` wraps.
  - Separate x/y counters generate the flags. x wraps at SCREEN_X_SIZE-1 and y increments on that wrap.
- **State machine** (IDLE, RUN, DRAIN):
  - IDLE -> RUN on `frame_start`. Pixel, x, y, bank and address counters clear to 0.
  - RUN -> DRAIN after the read for the last pixel (p = X*Y-1) issues.
  - DRAIN -> IDLE when the FIFO is empty and no read is in flight. `frame_done` pulses in that same cycle.
  - `frame_start` is ignored in RUN and DRAIN.
- **Issue rule.** In RUN, a read issues when `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` is 1 if `rd_issue` was high in the previous cycle.
  - `fifo_count` is the registered occupancy; a pop in the current cycle is not credited.
  - Counters advance only on issue.
- **Flag pipeline.**
  - sof/eol/eof for the issued pixel are delayed one cycle alongside the read.
  - They are written into the FIFO with `rdata`. FIFO entry width is COLOR_WIDTH+3.
- **Stream handshake.**
  - A pixel transfers when `pix_valid && pix_ready`.
  - Once `pix_valid` is high, `pix_data` and the flags stay stable until the transfer.
  - Pixels are never dropped or duplicated.
- **Abort** (any state):
  - Next state is IDLE and the FIFO is flushed.
  - Any `rdata` returning in the cycle after `abort` is discarded.
  - `frame_done` is not pulsed.
  - `abort` and `frame_start` in the same cycle: abort wins.
- **Idle read port.** When no read issues, `raddress`/`rselect` hold their last value and `rd_issue` is 0.

## Timing
- **Reset values.**
  - All outputs 0: `raddress`, `rselect`, `rd_issue`, `pix_*`, `busy`, `frame_done`.
  - State IDLE, FIFO empty, all counters 0.
- **Frame start.** `frame_start` sampled at cycle 0 gives `busy`=1 and the first `rd_issue` (bank 0, address 0) in cycle 1.
- **Read to stream.** `rdata` is captured into the FIFO at the end of cycle 2. `pix_valid`=1 in cycle 3.
- **Throughput.** With `pix_ready` held high, one issue and one pixel out per cycle.
  - Frame of N pixels: last issue at cycle N.
  - Last transfer at cycle N+2.
  - `frame_done` pulses and the block returns to IDLE in cycle N+3.
- **Backpressure.** With `pix_ready`=0, at most FIFO_DEPTH reads are outstanding (FIFO plus in flight).
  - Issue resumes in the cycle after a pop drops the sum below FIFO_DEPTH.

## Test plan
Small configuration: X=8, Y=2, CORES=4, FIFO_DEPTH=4, with a behavioural banked-memory model holding pixel p = 0x1000+p.
- **Reset:** assert `reset_n`=0 mid-frame -> all outputs 0 immediately. A later `frame_start` restarts at pixel 0.
- **Full frame, `pix_ready`=1:** `frame_start` -> issues (sel,addr) = (0,0),(1,0),(2,0),(3,0),(0,1)…(3,3) on cycles 1..16.
  - Stream 0x1000..0x100F on cycles 3..18.
  - `pix_sof` on 0x1000; `pix_eol` on 0x1007 and 0x100F; `pix_eof` on 0x100F.
  - `frame_done` on cycle 19.
- **Backpressure:** `pix_ready`=0 for cycles 1..12 -> exactly 4 issues, then stall.
  - `pix_data` holds 0x1000 while stalled.
  - After release, all 16 pixels arrive in order with no gaps or duplicates.
- **Ignored start:** second `frame_start` at cycle 6 -> no counter reset; the frame completes normally.
- **Abort:** `abort` after 5 transfers -> IDLE next cycle, `pix_valid`=0, `busy`=0, no `frame_done`.
  - A following `frame_start` streams from 0x1000 with `pix_sof`.
- **Random `pix_ready`** (50%) over 3 back-to-back frames -> the scoreboard matches every pixel and flag, and outstanding reads never exceed 4.
